alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Captures the ALU result, flags and exception code behind a valid/ready handshake, using a 2-entry skid buffer.
- Owns the architectural flags register (carry/zero/negative). The carry bit feeds back to the ALU `in_carry`.
- Freezes the pipe on a CPU exception until the control unit flushes.

Parameters:
- DEPTH, 2, skid buffer entries (fixed at 2; other values unsupported)
- RD_W, 5, destination register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream ALU op valid
- in_ready  out  1  stage can accept
- in_op  in  opcode_t  opcode of the op
- in_rd  in  RD_W  destination register
- in_flags_we  in  1  op updates flags
- in_result  in  quad_t  ALU result
- in_carry  in  1  ALU out_carry
- in_zero  in  1  ALU out_zero
- in_negative  in  1  ALU out_negitive
- in_exception  in  exception_t  ALU cpu_exception
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback accepts
- out_rd  out  RD_W  destination register
- out_result  out  quad_t  result to writeback
- out_exception  out  exception_t  exception of head entry
- flags_carry  out  1  architectural carry, to ALU in_carry
- flags_zero  out  1  architectural zero
- flags_negative  out  1  architectural negative
- halted  out  1  exception accepted, awaiting flush
- flush  in  1  synchronous clear of buffer and halt

Behaviour:
- Reset (async, rst_n=0):
  - buffer empty, so out_valid=0.
  - out_rd=0, out_result=0, out_exception=NONE.
  - All flags 0; halted=0.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Retire when out_valid & out_ready.
  - in_ready = !halted & (count<2). It is registered-state-derived and never depends on in_valid.
- Latency and ordering:
  - Accepted entry appears on out_* the next cycle at the earliest (1-cycle latency). Order is FIFO.
  - With count=1 and simultaneous accept+retire, count stays 1 and the new entry becomes head. Full throughput is 1 op/cycle.
  - count=2: in_ready=0. A retire that cycle frees a slot, and in_ready rises the next cycle.
  - count=0: out_valid=0. out_* hold their last values, and the bench must not check them.
- Flags:
  - Updated on the accept edge (not on retire), so a back-to-back ADC sees the new carry with no bubble.
  - Updated only if in_flags_we=1 and in_exception==NONE.
  - When updated: flags_carry<=in_carry, flags_zero<=in_zero, flags_negative<=in_negative.
- Exceptions:
  - Accepting an entry with in_exception!=NONE sets halted=1 next cycle. That entry is still buffered and presented so writeback can see out_exception.
  - Further accepts are blocked.
- Flush (priority over accept and retire):
  - Empties the buffer and clears halted on the next edge. in_ready and out_valid are 0 in the following cycle only if halted/empty rules apply.
  - Flags are not modified.
  - An accept in the flush cycle is discarded, including its flag update.
- Reset mid-operation: all state is cleared immediately and asynchronously. No partial retire occurs.
- State machine: RUN (halted=0) -> HALT on an accepted exception entry; HALT -> RUN on flush.
- Widths: result and data are passed through unmodified (64 bits). count is a 2-bit value in the range 0..2.

Optional Feature:
- Macro: ALU_RESULT_STAGE_STATS_EN.
- Defined:
  - Extra outputs retired_count (32) and exception_count (32).
  - retired_count increments on each retire.
  - exception_count increments on each accept carrying an exception.
  - Both wrap modulo 2^32, reset to 0, and are not cleared by flush.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package (defines): opcode_t, quad_t and exception_t (NONE, DIVIDE_BY_ZERO) already exist there.
- Add to the package:
  - alu_flags_t packed struct {carry, zero, negative}.
  - result_entry_t packed struct {rd, result, exception}.
- One sub-module, skid_buffer_2: a generic 2-entry valid/ready buffer of result_entry_t with a flush input.
- Flags register and halt FSM stay in alu_result_stage.

Test Plan:
- Reset, then accept ADD rd=3 result=0x5 carry=0, flags_we=1, out_ready=1 -> next cycle out_valid=1, out_rd=3, out_result=0x5; flags c/z/n=0/0/0.
- Accept ADD with carry=1 and result=0, immediately followed by an accept the next cycle -> flags_carry=1 and flags_zero=1 visible in the cycle of the second accept. A flags_we=0 op leaves them unchanged.
- out_ready=0 with 3 consecutive in_valid -> 2 accepted, in_ready=0 on the third; raise out_ready -> results retire in order, 1 per cycle.
- DIV with in_exception=DIVIDE_BY_ZERO, result 0 -> halted=1 and in_ready=0 the next cycle, out_exception=DIVIDE_BY_ZERO, flags unchanged; pulse flush -> out_valid=0, halted=0, in_ready=1.
- Flush asserted together with in_valid (flags_we=1, carry=1) -> entry dropped, flags_carry unchanged.
- Assert rst_n=0 mid-stream with 2 entries buffered -> out_valid=0 and flags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: opcodes, data words, exception codes,
// architectural flags and the buffered result entry.
package alu_result_stage_pkg;

    localparam int RD_W  = 5;
    localparam int DEPTH = 2;

    typedef logic [63:0] quad_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_MUL = 4'd7,
        OP_DIV = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        NONE           = 2'd0,
        DIVIDE_BY_ZERO = 2'd1
    } exception_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
    } alu_flags_t;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        quad_t           result;
        exception_t      exception;
    } result_entry_t;

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry valid/ready FIFO of result entries; flush empties it but leaves
// the head data in place so out_data holds its last value while empty.
module skid_buffer_2
    import alu_result_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  result_entry_t in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output result_entry_t out_data
);

    logic [1:0]    count;
    result_entry_t head;
    result_entry_t tail;
    logic          push;
    logic          pop;

    assign in_ready  = (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // draining the last entry keeps head as the held output
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: skid-buffered result capture, architectural flags and
// exception halt. ALU_RESULT_STAGE_STATS_EN adds retire/exception counters.
module alu_result_stage
    import alu_result_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  opcode_t         in_op,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_flags_we,
    input  quad_t           in_result,
    input  logic            in_carry,
    input  logic            in_zero,
    input  logic            in_negative,
    input  exception_t      in_exception,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RD_W-1:0] out_rd,
    output quad_t           out_result,
    output exception_t      out_exception,
    output logic            flags_carry,
    output logic            flags_zero,
    output logic            flags_negative,
    output logic            halted,
    input  logic            flush
`ifdef ALU_RESULT_STAGE_STATS_EN
    ,
    output logic [31:0]     retired_count,
    output logic [31:0]     exception_count
`endif
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    alu_flags_t    flags;
    result_entry_t in_entry;
    result_entry_t head;
    logic          buf_ready;
    logic          accept;
    logic          retire;
    logic          unused_op;

    // the opcode only travels with the op for debug visibility upstream
    assign unused_op = ^in_op;

    assign halted   = (state == HALT);
    assign in_ready = !halted & buf_ready;
    assign accept   = in_valid & in_ready & !flush;
    assign retire   = out_valid & out_ready & !flush;

    assign in_entry = '{rd: in_rd, result: in_result, exception: in_exception};

    skid_buffer_2 u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid & !halted),
        .in_ready  (buf_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_rd        = head.rd;
    assign out_result    = head.result;
    assign out_exception = head.exception;

    // flags move on accept so a dependent ADC right behind sees the new carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (accept && in_flags_we && in_exception == NONE) begin
            flags <= '{carry: in_carry, zero: in_zero, negative: in_negative};
        end
    end

    assign flags_carry    = flags.carry;
    assign flags_zero     = flags.zero;
    assign flags_negative = flags.negative;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RUN;
        end else if (state == RUN && accept && in_exception != NONE) begin
            state_nxt = HALT;
        end
    end

`ifdef ALU_RESULT_STAGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count   <= '0;
            exception_count <= '0;
        end else begin
            if (retire)                           retired_count   <= retired_count + 32'd1;
            if (accept && in_exception != NONE)   exception_count <= exception_count + 32'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, flags, halt/flush, reset.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    opcode_t         in_op;
    logic [RD_W-1:0] in_rd;
    logic            in_flags_we;
    quad_t           in_result;
    logic            in_carry;
    logic            in_zero;
    logic            in_negative;
    exception_t      in_exception;
    logic            out_valid;
    logic            out_ready;
    logic [RD_W-1:0] out_rd;
    quad_t           out_result;
    exception_t      out_exception;
    logic            flags_carry;
    logic            flags_zero;
    logic            flags_negative;
    logic            halted;
    logic            flush;

    int checks = 0;
    int errors = 0;

    alu_result_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_rd          (in_rd),
        .in_flags_we    (in_flags_we),
        .in_result      (in_result),
        .in_carry       (in_carry),
        .in_zero        (in_zero),
        .in_negative    (in_negative),
        .in_exception   (in_exception),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd         (out_rd),
        .out_result     (out_result),
        .out_exception  (out_exception),
        .flags_carry    (flags_carry),
        .flags_zero     (flags_zero),
        .flags_negative (flags_negative),
        .halted         (halted),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input opcode_t op, input logic [RD_W-1:0] rd,
                         input quad_t res, input logic we, input logic c, input logic z,
                         input logic n, input exception_t e);
        in_valid = v; in_op = op; in_rd = rd; in_result = res; in_flags_we = we;
        in_carry = c; in_zero = z; in_negative = n; in_exception = e;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, OP_ADD, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_exc", 64'(out_exception), 64'(NONE));
        chk("rst_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // single ADD, 1-cycle latency
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 5'd3, 64'h5, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_out_rd", 64'(out_rd), 64'd3);
        chk("add_out_result", out_result, 64'h5);
        chk("add_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'd0);

        // carry-producing ADD then ADC back-to-back
        drive(1'b1, OP_ADD, 5'd4, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, NONE);
        tick();
        chk("b2b_flags_carry", 64'(flags_carry), 64'd1);
        chk("b2b_flags_zero", 64'(flags_zero), 64'd1);
        chk("b2b_out_rd", 64'(out_rd), 64'd4);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, OP_ADC, 5'd5, 64'h10, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
        tick();
        chk("nowe_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'b110);
        chk("adc_out_rd", 64'(out_rd), 64'd5);
        chk("adc_out_result", out_result, 64'h10);
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // backpressure: two accepted, third blocked
        out_ready = 1'b0;
        drive(1'b1, OP_SUB, 5'd6, 64'h60, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        chk("bp_ready_1", 64'(in_ready), 64'd1);
        drive(1'b1, OP_SUB, 5'd7, 64'h70, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        drive(1'b1, OP_SUB, 5'd8, 64'h80, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        chk("bp_head_rd", 64'(out_rd), 64'd6);
        chk("bp_still_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_head_result", out_result, 64'h60);
        tick();
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_second_rd", 64'(out_rd), 64'd7);
        chk("bp_second_result", out_result, 64'h70);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // divide-by-zero halts the stage
        out_ready = 1'b0;
        drive(1'b1, OP_DIV, 5'd9, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, DIVIDE_BY_ZERO);
        tick();
        chk("exc_halted", 64'(halted), 64'd1);
        chk("exc_in_ready", 64'(in_ready), 64'd0);
        chk("exc_out_valid", 64'(out_valid), 64'd1);
        chk("exc_out_exc", 64'(out_exception), 64'(DIVIDE_BY_ZERO));
        chk("exc_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'b110);
        drive(1'b1, OP_ADD, 5'd10, 64'hA, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        chk("exc_blocked_rd", 64'(out_rd), 64'd9);
        chk("exc_blocked_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'b110);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_halted", 64'(halted), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

        // clear carry, then flush drops a carry-setting op
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 5'd11, 64'hB, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        chk("clr_flags_carry", 64'(flags_carry), 64'd0);
        in_valid = 1'b0;
        tick();
        drive(1'b1, OP_ADD, 5'd12, 64'hC, 1'b1, 1'b1, 1'b1, 1'b1, NONE);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flushacc_carry", 64'(flags_carry), 64'd0);
        chk("flushacc_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'd0);
        chk("flushacc_out_valid", 64'(out_valid), 64'd0);

        // async reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 5'd13, 64'hD, 1'b1, 1'b1, 1'b1, 1'b1, NONE);
        tick();
        drive(1'b1, OP_ADD, 5'd14, 64'hE, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        chk("pre_rst_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_flags", {61'd0, flags_carry, flags_zero, flags_negative}, 64'd0);
        chk("async_out_rd", 64'(out_rd), 64'd0);
        chk("async_halted", 64'(halted), 64'd0);
        #10;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
